// File: rtl/cbl_sched.sv
// rtl/cbl_sched.sv - CBL stage sequencer (optional WAIT timeout: CBL_TIMEOUT_EN)
module cbl_sched #(
  parameter int CH_W       = 8,
  parameter int IMG_AW     = 12,
  parameter int W_AW       = 10,
  parameter int IMG_STRIDE = 16,
  parameter int W_STRIDE   = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk_en,
  input  logic              rst,
  input  logic              start,
  input  logic [CH_W-1:0]   in_ch_cfg,
  input  logic [CH_W-1:0]   out_ch_cfg,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              load_req,
  input  logic              load_ack,
  output logic [IMG_AW-1:0] img_base_addr,
  output logic [W_AW-1:0]   w_base_addr,
  output logic              conv_en,
  input  logic              conv_fin,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FIRE,
    S_WAIT,
    S_ACC,
    S_EMIT,
    S_DONE
`ifdef CBL_TIMEOUT_EN
    , S_ERR
`endif
  } state_t;

  localparam logic [CH_W-1:0]   ONE_CH   = CH_W'(1);
  localparam logic [IMG_AW-1:0] IMG_STEP = IMG_AW'(IMG_STRIDE);
  localparam logic [W_AW-1:0]   W_STEP   = W_AW'(W_STRIDE);

  state_t              state_q;
  logic [CH_W-1:0]     in_ch_q;
  logic [CH_W-1:0]     out_ch_q;
  logic [CH_W-1:0]     ic_q;
  logic [CH_W-1:0]     oc_q;
  logic [IMG_AW-1:0]   img_q;
  logic [W_AW-1:0]     w_q;
  logic                busy_q;
  logic                done_q;
  logic                load_req_q;
  logic                conv_en_q;
  logic                acc_clr_q;
  logic                acc_en_q;
  logic                out_valid_q;

`ifdef CBL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] wait_cnt_q;
  logic            err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy          = busy_q;
  assign done          = done_q;
  assign load_req      = load_req_q;
  assign conv_en       = conv_en_q;
  assign acc_clr       = acc_clr_q;
  assign acc_en        = acc_en_q;
  assign out_valid     = out_valid_q;
  assign out_ch        = oc_q;
  assign img_base_addr = img_q;
  assign w_base_addr   = w_q;

  // Sequencer FSM; every output is registered and set on the transition into its state
  always_ff @(posedge clk_en or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ch_q     <= '0;
      out_ch_q    <= '0;
      ic_q        <= '0;
      oc_q        <= '0;
      img_q       <= '0;
      w_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      load_req_q  <= 1'b0;
      conv_en_q   <= 1'b0;
      acc_clr_q   <= 1'b0;
      acc_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef CBL_TIMEOUT_EN
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; only a specific transition raises them for one cycle
      done_q    <= 1'b0;
      conv_en_q <= 1'b0;
      acc_clr_q <= 1'b0;
      acc_en_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
`ifdef CBL_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
            if (in_ch_cfg != '0 && out_ch_cfg != '0) begin
              in_ch_q    <= in_ch_cfg;
              out_ch_q   <= out_ch_cfg;
              ic_q       <= '0;
              oc_q       <= '0;
              img_q      <= '0;
              w_q        <= '0;
              load_req_q <= 1'b1;
              state_q    <= S_LOAD;
            end else begin
              // Empty layer: complete without touching the datapath
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_LOAD: begin
          if (load_ack) begin
            load_req_q <= 1'b0;
            conv_en_q  <= 1'b1;
            acc_clr_q  <= (ic_q == '0);
            state_q    <= S_FIRE;
          end
        end
        S_FIRE: begin
`ifdef CBL_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (conv_fin) begin
            acc_en_q <= 1'b1;
            state_q  <= S_ACC;
          end
`ifdef CBL_TIMEOUT_EN
          else if (wait_cnt_q == TO_W'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_ERR;
          end else begin
            wait_cnt_q <= wait_cnt_q + TO_W'(1);
          end
`endif
        end
        S_ACC: begin
          if (ic_q == in_ch_q - ONE_CH) begin
            out_valid_q <= 1'b1;
            state_q     <= S_EMIT;
          end else begin
            // Weight base is a running sum over (oc, ic), avoiding a multiplier
            ic_q       <= ic_q + ONE_CH;
            img_q      <= img_q + IMG_STEP;
            w_q        <= w_q + W_STEP;
            load_req_q <= 1'b1;
            state_q    <= S_LOAD;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (oc_q == out_ch_q - ONE_CH) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              oc_q       <= oc_q + ONE_CH;
              ic_q       <= '0;
              img_q      <= '0;
              w_q        <= w_q + W_STEP;
              load_req_q <= 1'b1;
              state_q    <= S_LOAD;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
`ifdef CBL_TIMEOUT_EN
        S_ERR: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
`endif
        default: begin
          busy_q      <= 1'b0;
          load_req_q  <= 1'b0;
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cbl_sched.sv
// tb/tb_cbl_sched.sv - scoreboard bench for cbl_sched
`timescale 1ns/1ps
module tb_cbl_sched;
  localparam int IMG_STRIDE = 16;
  localparam int W_STRIDE   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  in_ch_cfg = '0;
  logic [7:0]  out_ch_cfg = '0;
  logic        busy, done, err, load_req, conv_en, acc_clr, acc_en, out_valid;
  logic        load_ack = 1'b1;
  logic        conv_fin = 1'b0;
  logic        out_ready = 1'b1;
  logic [11:0] img_base_addr;
  logic [9:0]  w_base_addr;
  logic [7:0]  out_ch;

  cbl_sched dut (
    .clk_en(clk), .rst(rst), .start(start), .in_ch_cfg(in_ch_cfg), .out_ch_cfg(out_ch_cfg),
    .busy(busy), .done(done), .err(err), .load_req(load_req), .load_ack(load_ack),
    .img_base_addr(img_base_addr), .w_base_addr(w_base_addr), .conv_en(conv_en),
    .conv_fin(conv_fin), .acc_clr(acc_clr), .acc_en(acc_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_ch(out_ch)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0, done_cyc = 0, load_cnt = 0, conv_cnt = 0, oval_cnt = 0;
  int start_cyc = 0, d0 = 0;
  logic fin_en = 1'b1, fin_pend = 1'b0, ack_rand = 1'b0;
  int rdy_mode = 1;
  logic [31:0] conv_q[$];
  logic [31:0] emit_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Datapath/loader/downstream responders
  initial forever begin
    @(posedge clk); #1;
    conv_fin = fin_en && fin_pend;
    fin_pend = conv_en;
    load_ack = ack_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    out_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
  end

  // Output monitor / scoreboard consumer
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (conv_en) begin
        conv_cnt++;
        check("conv_expected", conv_q.size() > 0, 1);
        if (conv_q.size() > 0)
          check("conv_fields", {acc_clr, out_ch, img_base_addr, w_base_addr}, conv_q.pop_front());
      end
      if (out_valid && out_ready) begin
        check("emit_expected", emit_q.size() > 0, 1);
        if (emit_q.size() > 0) check("emit_oc", out_ch, emit_q.pop_front());
      end
      if (out_valid) oval_cnt++;
      if (load_req) load_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic push_layer(input int nin, input int nout);
    logic [11:0] img;
    logic [9:0]  w;
    for (int o = 0; o < nout; o++) begin
      for (int i = 0; i < nin; i++) begin
        img = 12'(i * IMG_STRIDE);
        w   = 10'((o * nin + i) * W_STRIDE);
        conv_q.push_back({1'(i == 0), 8'(o), img, w});
      end
      emit_q.push_back(32'(o));
    end
  endtask

  task automatic do_start(input int nin, input int nout);
    @(posedge clk); #1;
    in_ch_cfg = 8'(nin);
    out_ch_cfg = 8'(nout);
    start = 1'b1;
    start_cyc = cyc;
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    in_ch_cfg = 8'hAA;
    out_ch_cfg = 8'h55;
  endtask

  task automatic wait_done(input string tag, input int budget, input int lat);
    int k;
    k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check({tag, "_done_seen"}, done_cnt - d0, 1);
    if (lat >= 0) check({tag, "_latency"}, done_cyc - start_cyc, lat);
    @(negedge clk); #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_conv_left"}, conv_q.size(), 0);
    check({tag, "_emit_left"}, emit_q.size(), 0);
  endtask

  initial begin
    int k, l0, c0, v0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outs", {busy, done, err, load_req, conv_en, acc_clr, acc_en, out_valid}, 0);
    check("rst_addr", {out_ch, img_base_addr, w_base_addr}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // in=3, out=2 at full speed
    push_layer(3, 2);
    do_start(3, 2);
    wait_done("l3x2", 200, 27);
    check("l3x2_conv_cnt", conv_cnt, 6);
    check("err_clear", err, 0);

    // in=2, out=2 address walk
    c0 = conv_cnt;
    push_layer(2, 2);
    do_start(2, 2);
    wait_done("l2x2", 200, 19);
    check("l2x2_conv_cnt", conv_cnt - c0, 4);

    // backpressure in EMIT, plus an ignored start while busy
    rdy_mode = 0;
    push_layer(2, 2);
    do_start(2, 2);
    k = 0;
    while (!out_valid && k < 50) begin
      @(negedge clk); #1;
      k++;
    end
    check("bp_valid_seen", out_valid, 1);
    l0 = load_cnt;
    start = 1'b1;
    in_ch_cfg = 8'd1;
    out_ch_cfg = 8'd1;
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", {out_valid, out_ch, img_base_addr, w_base_addr}, {1'b1, 8'd0, 12'd16, 10'd4});
      @(negedge clk); #1;
    end
    start = 1'b0;
    check("bp_no_load", load_cnt - l0, 0);
    rdy_mode = 1;
    wait_done("bp", 200, -1);

    // zero channel configs complete immediately
    l0 = load_cnt;
    c0 = conv_cnt;
    do_start(0, 3);
    wait_done("zin", 20, 1);
    do_start(2, 0);
    wait_done("zout", 20, 1);
    check("zero_no_load", load_cnt - l0, 0);
    check("zero_no_conv", conv_cnt - c0, 0);

    // reset in WAIT during the second output channel
    push_layer(2, 2);
    do_start(2, 2);
    k = 0;
    while (!(conv_en && out_ch == 8'd1) && k < 100) begin
      @(negedge clk); #1;
      k++;
    end
    check("rst_mid_reached", {conv_en, out_ch}, {1'b1, 8'd1});
    @(posedge clk); #1;
    rst = 1'b1;
    d0 = done_cnt;
    v0 = oval_cnt;
    @(negedge clk);
    check("rst_mid_outs", {busy, done, err, load_req, conv_en, acc_clr, acc_en, out_valid}, 0);
    check("rst_mid_addr", {out_ch, img_base_addr, w_base_addr}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    conv_q.delete();
    emit_q.delete();
    repeat (5) @(negedge clk);
    check("rst_mid_no_done", done_cnt - d0, 0);
    check("rst_mid_no_valid", oval_cnt - v0, 0);
    push_layer(2, 1);
    do_start(2, 1);
    wait_done("post_rst", 100, 10);

    // random load_ack and out_ready
    ack_rand = 1'b1;
    rdy_mode = 2;
    push_layer(3, 3);
    do_start(3, 3);
    wait_done("rand", 2000, -1);
    ack_rand = 1'b0;
    rdy_mode = 1;

`ifdef CBL_TIMEOUT_EN
    fin_en = 1'b0;
    conv_q.push_back({1'b1, 8'd0, 12'd0, 10'd0});
    do_start(1, 1);
    wait_done("tmo", 400, 258);
    check("tmo_err", err, 1);
    repeat (3) @(negedge clk);
    check("tmo_err_sticky", err, 1);
    fin_en = 1'b1;
    push_layer(1, 1);
    do_start(1, 1);
    @(negedge clk);
    check("tmo_err_cleared", err, 0);
    wait_done("tmo_next", 100, 6);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cbl_sched.md
# cbl_sched

Sequencer for one CBL stage (conv → bias → ReLU). It loops over output channels and, inside each, over input channels. For each pair it requests buffer loads, fires the convolution engine with a one-cycle start pulse, waits for its finish strobe and drives the accumulator controls. After the last input channel of an output channel, it presents the finished output channel on a valid/ready port. It sits between the layer host and the conv/ReLU datapath and drives every control input that datapath needs.

## Interface
Parameters:
- CH_W, 8, width of channel counters and channel-count config
- IMG_AW, 12, image buffer address width
- W_AW, 10, weight buffer address width
- IMG_STRIDE, 16, image words per input channel
- W_STRIDE, 4, weight words per (oc, ic) kernel
- TIMEOUT, 255, maximum WAIT cycles (used only with the macro)

Ports:
- clk_en  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  layer start; sampled in IDLE only
- in_ch_cfg  in  CH_W  input channel count; latched on an accepted start
- out_ch_cfg  in  CH_W  output channel count; latched on an accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  sticky timeout flag
- load_req  out  1  buffer load request; high throughout LOAD
- load_ack  in  1  loader acknowledge
- img_base_addr  out  IMG_AW  current image base = ic*IMG_STRIDE
- w_base_addr  out  W_AW  current weight base = (oc*in_ch+ic)*W_STRIDE
- conv_en  out  1  one-cycle conv start pulse
- conv_fin  in  1  conv finished strobe
- acc_clr  out  1  clear accumulator; pulses with conv_en when ic==0
- acc_en  out  1  accumulate the conv result; one-cycle pulse
- out_valid  out  1  output channel ready for the ReLU/writeback stage
- out_ready  in  1  downstream accept
- out_ch  out  CH_W  index of the current output channel (oc)

## Operation
- States: IDLE, LOAD, FIRE, WAIT, ACC, EMIT, DONE, plus ERR with the macro.
- IDLE:
  - start with both cfg fields nonzero → latch cfg; clear oc, ic and both addresses; go to LOAD.
  - start with either cfg field zero → go to DONE. No load and no conv is issued.
- LOAD: load_req=1 while in this state. Go to FIRE on the first cycle load_ack=1.
- FIRE: conv_en=1 and acc_clr=(ic==0) for exactly this cycle; go to WAIT.
- WAIT: conv_fin is sampled only in this state. conv_fin=1 → go to ACC. A conv_fin arriving in any other state is ignored.
- ACC: acc_en=1.
  - ic==in_ch-1 → go to EMIT.
  - Otherwise: ic+=1, img_base_addr+=IMG_STRIDE, w_base_addr+=W_STRIDE; go to LOAD.
- EMIT: out_valid=1; out_ch is held stable. Leaves on out_valid & out_ready:
  - oc==out_ch-1 → go to DONE.
  - Otherwise: oc+=1, ic=0, img_base_addr=0, w_base_addr+=W_STRIDE; go to LOAD.
- DONE: done=1 for one cycle; go to IDLE.
- start while busy is ignored. cfg inputs are not sampled after they are latched.
- Address arithmetic is unsigned and wraps modulo 2^IMG_AW and 2^W_AW. There is no overflow flag. w_base_addr is a running sum, so no multiplier is needed.
- Reset value of every output is 0. Counters are 0 and the state is IDLE.
- Reset asserted mid-operation aborts immediately: no done pulse and no out_valid.

## Timing
- An accepted start at edge N puts the block in LOAD in cycle N+1.
- Minimum per (oc, ic): 4 cycles (LOAD, FIRE, WAIT, ACC), with load_ack already high and conv_fin arriving one cycle after conv_en.
- Minimum per output channel: 4*in_ch + 1 cycles (the extra cycle is EMIT).
- Minimum layer time from start to the done pulse: out_ch*(4*in_ch+1) + 1 cycles.
- out_valid can be held high indefinitely by backpressure. out_ch and both addresses stay constant while it is held.
- busy falls in the cycle after the done pulse.

## Configuration
- CBL_TIMEOUT_EN defined:
  - A WAIT counter clears on entry to WAIT.
  - If TIMEOUT cycles pass without conv_fin, the FSM goes to ERR. ERR sets err=1, pulses done for one cycle and returns to IDLE.
  - err stays set until the next accepted start.
- CBL_TIMEOUT_EN undefined: WAIT waits forever, err is tied 0 and the ERR state does not exist.

## Test plan
- in_ch=3, out_ch=2, load_ack held high, conv_fin 1 cycle after conv_en, out_ready high → 6 conv_en pulses, acc_clr on the 1st and 4th, out_ch 0 then 1, done 27 cycles after start.
- in_ch=2, out_ch=2 → w_base_addr sequence 0, 4, 8, 12; img_base_addr sequence 0, 16, 0, 16.
- out_ready held low for 10 cycles in EMIT → out_valid, out_ch and the addresses stay stable; no LOAD until out_ready rises.
- in_ch=0 with start → done one cycle after start; no load_req and no conv_en.
- rst asserted in WAIT during the 2nd output channel → all outputs 0 next cycle, no done; a following start runs normally from oc=0.
- CBL_TIMEOUT_EN with TIMEOUT=255 and conv_fin never asserted → err=1 and a done pulse after 255 WAIT cycles; err clears on the next start.
